pep_mmacc_boram_sched: RTL and testbench

PEP_MMACC_BORAM_SCHED -- requirements
Module: pep_mmacc_boram_sched

---
 rtl/pep_common_param_pkg.sv | 6 +
 rtl/pep_mmacc_common_param_pkg.sv | 16 +
 rtl/pep_mmacc_boram_sched_pid_fifo.sv | 65 ++++++
 rtl/pep_mmacc_boram_sched.sv | 161 ++++++++++++++++
 tb/tb_pep_mmacc_boram_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pep_common_param_pkg.sv
// Shared PBS-engine sizing constants: PID slot count, PID width and LWE dimension.
package pep_common_param_pkg;
  localparam int TOTAL_PBS_NB = 8;
  localparam int PID_W        = $clog2(TOTAL_PBS_NB);
  localparam int LWE_K        = 3;
endpackage

// File: rtl/pep_mmacc_common_param_pkg.sv
// MMACC-level types: per-PID body-RAM slot state and correction counter width.
package pep_mmacc_common_param_pkg;
  import pep_common_param_pkg::*;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_WAIT = 2'd1,
    SLOT_PEND = 2'd2
  } boram_slot_e;

  localparam int BORAM_SCHED_CNT_W = $clog2(LWE_K + 1);

  function automatic int boram_sched_cnt_w(input int corr_nb);
    return $clog2(corr_nb + 1);
  endfunction
endpackage

// File: rtl/pep_mmacc_boram_sched_pid_fifo.sv
// Register-based PID FIFO; push and pop may happen in the same cycle, even when full.
module pep_mmacc_boram_sched_pid_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         s_rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every _d takes its _q value first so no branch leaves it unassigned (no latch).
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state is updated with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy count alone says which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
endmodule

// File: rtl/pep_mmacc_boram_sched.sv
// Body-RAM read scheduler: issues reads in first-body-write order once all corrections land.
// Optional sticky protocol checker enabled by PEP_MMACC_BORAM_SCHED_ERR_EN.
module pep_mmacc_boram_sched
  import pep_common_param_pkg::*;
  import pep_mmacc_common_param_pkg::*;
#(
  parameter int PBS_NB  = TOTAL_PBS_NB,
  parameter int CORR_NB = LWE_K
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              ks_boram_wr_en,
  input  logic [PID_W-1:0]  ks_boram_wr_pid,
  input  logic              ks_boram_wr_parity,
  input  logic              seq_boram_corr_wr_en,
  input  logic [PID_W-1:0]  seq_boram_corr_wr_pid,
  output logic              boram_rd_vld,
  input  logic              boram_rd_rdy,
  output logic [PID_W-1:0]  boram_rd_pid,
  output logic              boram_rd_parity,
  input  logic              boram_sxt_data_vld,
  input  logic              boram_sxt_data_rdy,
  output logic [PBS_NB-1:0] sched_pid_busy,
  output logic              sched_error
);
  localparam int CNT_W = boram_sched_cnt_w(CORR_NB);
  localparam logic [CNT_W-1:0] CORR_CNT = CNT_W'(CORR_NB);

  boram_slot_e      state_q [PBS_NB];
  boram_slot_e      state_d [PBS_NB];
  logic [CNT_W-1:0] cnt_q   [PBS_NB];
  logic [CNT_W-1:0] cnt_d   [PBS_NB];
  logic             par_q   [PBS_NB];
  logic             par_d   [PBS_NB];

  logic             rd_vld_q, rd_vld_d;
  logic [PID_W-1:0] rd_pid_q, rd_pid_d;
  logic             rd_parity_q, rd_parity_d;

  logic [PID_W-1:0] ord_head, out_head;
  logic             ord_empty, ord_full, out_empty, out_full;
  logic             load, fire, cpl, cpl_ok, ks_push;

  assign fire   = rd_vld_q && boram_rd_rdy;
  assign cpl    = boram_sxt_data_vld && boram_sxt_data_rdy;
  assign cpl_ok = cpl && !out_empty;
  // The output register is a pipeline stage: it refills from the order head whenever it frees up.
  assign load   = !ord_empty && (cnt_q[ord_head] == CORR_CNT) && (!rd_vld_q || boram_rd_rdy);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    rd_vld_d    = rd_vld_q;
    rd_pid_d    = rd_pid_q;
    rd_parity_d = rd_parity_q;
    ks_push     = 1'b0;

    if (fire) begin
      rd_vld_d           = 1'b0;
      state_d[rd_pid_q]  = SLOT_PEND;
      par_d[rd_pid_q]    = ~par_q[rd_pid_q];
    end
    if (load) begin
      rd_vld_d    = 1'b1;
      rd_pid_d    = ord_head;
      rd_parity_d = par_q[ord_head];
    end
    // Completion is applied before same-cycle correction and body writes to the same PID.
    if (cpl_ok) begin
      state_d[out_head] = SLOT_IDLE;
      cnt_d[out_head]   = '0;
    end
    if (seq_boram_corr_wr_en && (cnt_d[seq_boram_corr_wr_pid] != CORR_CNT)) begin
      cnt_d[seq_boram_corr_wr_pid] = cnt_d[seq_boram_corr_wr_pid] + CNT_W'(1);
    end
    if (ks_boram_wr_en && (state_d[ks_boram_wr_pid] == SLOT_IDLE)) begin
      state_d[ks_boram_wr_pid] = SLOT_WAIT;
      ks_push                  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      for (int i = 0; i < PBS_NB; i++) begin
        state_q[i] <= SLOT_IDLE;
        cnt_q[i]   <= '0;
        par_q[i]   <= 1'b0;
      end
      rd_vld_q    <= 1'b0;
      rd_pid_q    <= '0;
      rd_parity_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      rd_vld_q    <= rd_vld_d;
      rd_pid_q    <= rd_pid_d;
      rd_parity_q <= rd_parity_d;
    end
  end

  pep_mmacc_boram_sched_pid_fifo #(.DEPTH(PBS_NB), .W(PID_W)) u_order_fifo (
    .clk       (clk),
    .s_rst_n   (s_rst_n),
    .push      (ks_push),
    .push_data (ks_boram_wr_pid),
    .pop       (load),
    .head      (ord_head),
    .empty     (ord_empty),
    .full      (ord_full)
  );

  pep_mmacc_boram_sched_pid_fifo #(.DEPTH(PBS_NB), .W(PID_W)) u_outstanding_fifo (
    .clk       (clk),
    .s_rst_n   (s_rst_n),
    .push      (fire),
    .push_data (rd_pid_q),
    .pop       (cpl_ok),
    .head      (out_head),
    .empty     (out_empty),
    .full      (out_full)
  );

  always_comb begin
    for (int i = 0; i < PBS_NB; i++) begin
      sched_pid_busy[i] = (state_q[i] != SLOT_IDLE);
    end
  end

  assign boram_rd_vld    = rd_vld_q;
  assign boram_rd_pid    = rd_pid_q;
  assign boram_rd_parity = rd_parity_q;

  // Body parity is carried by the write itself; occupancy flags cannot overflow by construction.
  logic unused_sigs;
  assign unused_sigs = ^{ks_boram_wr_parity, ord_full, out_full};

`ifdef PEP_MMACC_BORAM_SCHED_ERR_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] corr_pre;

  always_comb begin
    corr_pre = cnt_q[seq_boram_corr_wr_pid];
    if (cpl_ok && (out_head == seq_boram_corr_wr_pid)) corr_pre = '0;
    err_d = err_q;
    if (ks_boram_wr_en && (state_d[ks_boram_wr_pid] == SLOT_PEND)) err_d = 1'b1;
    if (seq_boram_corr_wr_en && (corr_pre == CORR_CNT))            err_d = 1'b1;
    if (cpl && out_empty)                                          err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign sched_error = err_q;
`else
  assign sched_error = 1'b0;
`endif
endmodule

// File: tb/tb_pep_mmacc_boram_sched.sv
// Directed bench for pep_mmacc_boram_sched: a vector table plus hand-written multi-cycle sequences.
module tb_pep_mmacc_boram_sched;
  import pep_common_param_pkg::*;

  localparam int NB = TOTAL_PBS_NB;
`ifdef PEP_MMACC_BORAM_SCHED_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic             ks_en;
    logic [PID_W-1:0] ks_pid;
    logic             ks_par;
    logic             corr_en;
    logic [PID_W-1:0] corr_pid;
    logic             rdy;
    logic             cpl;
    logic             exp_vld;
    logic [PID_W-1:0] exp_pid;
    logic             exp_par;
    logic [NB-1:0]    exp_busy;
  } vec_t;

  logic             clk = 1'b0;
  logic             s_rst_n;
  logic             ks_en, ks_par, corr_en, rdy, sxt_vld, sxt_rdy;
  logic [PID_W-1:0] ks_pid, corr_pid;
  logic             rd_vld, rd_parity, sched_error;
  logic [PID_W-1:0] rd_pid;
  logic [NB-1:0]    busy;

  int   n_vec = 0;
  int   n_err = 0;
  logic err_exp = 1'b0;
  vec_t tbl [14];

  always #5 clk = ~clk;

  pep_mmacc_boram_sched dut (
    .clk                   (clk),
    .s_rst_n               (s_rst_n),
    .ks_boram_wr_en        (ks_en),
    .ks_boram_wr_pid       (ks_pid),
    .ks_boram_wr_parity    (ks_par),
    .seq_boram_corr_wr_en  (corr_en),
    .seq_boram_corr_wr_pid (corr_pid),
    .boram_rd_vld          (rd_vld),
    .boram_rd_rdy          (rdy),
    .boram_rd_pid          (rd_pid),
    .boram_rd_parity       (rd_parity),
    .boram_sxt_data_vld    (sxt_vld),
    .boram_sxt_data_rdy    (sxt_rdy),
    .sched_pid_busy        (busy),
    .sched_error           (sched_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ke, input int kp, input logic kpar, input logic ce,
                              input int cp, input logic r, input logic c, input logic ev,
                              input int ep, input logic epar, input int eb);
    vec_t v;
    v.ks_en = ke;  v.ks_pid = PID_W'(kp); v.ks_par = kpar;
    v.corr_en = ce; v.corr_pid = PID_W'(cp); v.rdy = r; v.cpl = c;
    v.exp_vld = ev; v.exp_pid = PID_W'(ep); v.exp_par = epar; v.exp_busy = NB'(eb);
    return v;
  endfunction

  // Present one cycle of inputs, let the edge consume them, then sample 1 ns later.
  task automatic drive(input logic ke, input int kp, input logic kpar, input logic ce,
                       input int cp, input logic r, input logic c);
    ks_en = ke; ks_pid = PID_W'(kp); ks_par = kpar;
    corr_en = ce; corr_pid = PID_W'(cp); rdy = r; sxt_vld = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic ev, input int ep, input logic epar,
                            input int eb);
    check({name, ".vld"}, 32'(rd_vld), 32'(ev));
    if (ev) begin
      check({name, ".pid"}, 32'(rd_pid), 32'(ep));
      check({name, ".par"}, 32'(rd_parity), 32'(epar));
    end
    check({name, ".busy"}, 32'(busy), 32'(eb));
    check({name, ".err"}, 32'(sched_error), 32'(err_exp));
  endtask

  task automatic corr_n(input string name, input int pid, input int n, input int eb);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 1, pid, 0, 0);
      expect_out(name, 0, 0, 0, eb);
    end
  endtask

  initial begin
    s_rst_n = 1'b0; sxt_rdy = 1'b1;
    ks_en = 0; ks_pid = '0; ks_par = 0; corr_en = 0; corr_pid = '0; rdy = 0; sxt_vld = 0;

    // Two full rounds on pid 3: parity 0 then 1, latency one cycle after the counter saturates.
    tbl[0]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 'h08);
    tbl[1]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 'h08);
    tbl[2]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 'h08);
    tbl[3]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 'h08);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 'h08);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h08);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00);
    tbl[7]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 'h08);
    tbl[8]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 'h08);
    tbl[9]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 'h08);
    tbl[10] = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 'h08);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 1, 3, 1, 'h08);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h08);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00);

    // Reset state.
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 2, 0, 1, 2, 1, 1);
    check("rst.vld", 32'(rd_vld), 0);
    check("rst.pid", 32'(rd_pid), 0);
    check("rst.par", 32'(rd_parity), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.err", 32'(sched_error), 0);
    s_rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ks_en, int'(tbl[i].ks_pid), tbl[i].ks_par, tbl[i].corr_en,
            int'(tbl[i].corr_pid), tbl[i].rdy, tbl[i].cpl);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].exp_vld, int'(tbl[i].exp_pid),
                 tbl[i].exp_par, int'(tbl[i].exp_busy));
    end

    // Order: pid 1 written first blocks pid 2 even though pid 2 saturates first.
    drive(1, 1, 0, 0, 0, 0, 0); expect_out("ord.ks1", 0, 0, 0, 'h02);
    drive(1, 2, 0, 0, 0, 0, 0); expect_out("ord.ks2", 0, 0, 0, 'h06);
    corr_n("ord.c2", 2, LWE_K, 'h06);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("ord.blk0", 0, 0, 0, 'h06);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("ord.blk1", 0, 0, 0, 'h06);
    corr_n("ord.c1", 1, LWE_K, 'h06);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("ord.rd1", 1, 1, 0, 'h06);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("ord.rd2", 1, 2, 0, 'h06);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("ord.done", 0, 0, 0, 'h06);
    drive(0, 0, 0, 0, 0, 0, 1); expect_out("ord.cpl1", 0, 0, 0, 'h04);
    drive(0, 0, 0, 0, 0, 0, 1); expect_out("ord.cpl2", 0, 0, 0, 'h00);

    // Backpressure: command held stable while rdy is low.
    drive(1, 4, 0, 0, 0, 0, 0); expect_out("bp.ks", 0, 0, 0, 'h10);
    corr_n("bp.c", 4, LWE_K, 'h10);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0); expect_out($sformatf("bp.hold%0d", i), 1, 4, 0, 'h10);
    end
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("bp.issue", 0, 0, 0, 'h10);
    drive(0, 0, 0, 0, 0, 0, 1); expect_out("bp.cpl", 0, 0, 0, 'h00);

    // pid 0: completion, body write and correction in one cycle -> requeued with count 1.
    drive(1, 0, 0, 0, 0, 0, 0); expect_out("rq.ks", 0, 0, 0, 'h01);
    corr_n("rq.c", 0, LWE_K, 'h01);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("rq.rd0", 1, 0, 0, 'h01);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("rq.pend", 0, 0, 0, 'h01);
    drive(1, 0, 1, 1, 0, 0, 1); expect_out("rq.same", 0, 0, 0, 'h01);
    corr_n("rq.c2", 0, LWE_K - 1, 'h01);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("rq.rd1", 1, 0, 1, 'h01);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("rq.pend2", 0, 0, 0, 'h01);
    drive(0, 0, 0, 0, 0, 0, 1); expect_out("rq.cpl", 0, 0, 0, 'h00);

    // Body write to a pending PID raises the sticky error when checking is built in.
    drive(1, 5, 0, 0, 0, 0, 0); expect_out("err.ks", 0, 0, 0, 'h20);
    corr_n("err.c", 5, LWE_K, 'h20);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("err.rd", 1, 5, 0, 'h20);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("err.pend", 0, 0, 0, 'h20);
    err_exp = ERR_ON;
    drive(1, 5, 1, 0, 0, 0, 0); expect_out("err.set", 0, 0, 0, 'h20);
    drive(0, 0, 0, 0, 0, 0, 0); expect_out("err.hold0", 0, 0, 0, 'h20);
    drive(0, 0, 0, 0, 0, 0, 1); expect_out("err.hold1", 0, 0, 0, 'h00);

    // Reset mid-operation with three PIDs queued and a command pending.
    drive(1, 1, 0, 0, 0, 0, 0); expect_out("mr.ks1", 0, 0, 0, 'h02);
    drive(1, 2, 0, 0, 0, 0, 0); expect_out("mr.ks2", 0, 0, 0, 'h06);
    drive(1, 6, 0, 0, 0, 0, 0); expect_out("mr.ks6", 0, 0, 0, 'h46);
    corr_n("mr.c", 1, LWE_K, 'h46);
    drive(0, 0, 0, 0, 0, 0, 0); expect_out("mr.vld", 1, 1, 1, 'h46);
    s_rst_n = 1'b0; err_exp = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0); expect_out("mr.rst", 0, 0, 0, 'h00);
    s_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0); expect_out($sformatf("mr.quiet%0d", i), 0, 0, 0, 'h00);
    end
    drive(1, 1, 0, 0, 0, 0, 0); expect_out("mr.new", 0, 0, 0, 'h02);
    corr_n("mr.c2", 1, LWE_K, 'h02);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("mr.rd", 1, 1, 0, 'h02);
    drive(0, 0, 0, 0, 0, 1, 0); expect_out("mr.fire", 0, 0, 0, 'h02);
    drive(0, 0, 0, 0, 0, 0, 1); expect_out("mr.cpl", 0, 0, 0, 'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
